// File: rtl/udt_pkt_dispatch.sv
// UDT packet classifier/router: decodes the first-beat header and forwards whole
// packets to one of NUM_CH channels through a single registered output slot.
module udt_pkt_dispatch #(
    parameter int unsigned          DATA_W  = 64,
    parameter int unsigned          NUM_CH  = 8,
    parameter logic [NUM_CH-1:0]    TYPE_EN = {NUM_CH{1'b1}},
    parameter int unsigned          CNT_W   = 16,
    localparam int unsigned         KEEP_W  = DATA_W / 8,
    localparam int unsigned         CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                core_clk,
    input  logic                core_rst,
    input  logic [DATA_W-1:0]   in_tdata,
    input  logic [KEEP_W-1:0]   in_tkeep,
    input  logic                in_tvalid,
    output logic                in_tready,
    input  logic                in_tlast,
    output logic [DATA_W-1:0]   out_tdata,
    output logic [KEEP_W-1:0]   out_tkeep,
    output logic                out_tlast,
    output logic [NUM_CH-1:0]   out_tvalid,
    input  logic [NUM_CH-1:0]   out_tready,
    output logic [CH_W-1:0]     cur_ch,
    output logic                busy,
    output logic [CNT_W-1:0]    drop_cnt,
    output logic [CNT_W-1:0]    runt_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CH_W-1:0]    out_ch_q;
    logic               out_pending;
    logic               accept;
    logic               drain;
    logic [15:0]        hdr_ch;
    logic               hdr_drop;
    logic               hdr_runt;
    logic               load;
    logic               set_ch;
    logic [CH_W-1:0]    load_ch;
    logic               inc_drop;
    logic               inc_runt;

    // Header decode; 16-bit index so type 0x7FFF lands at 0x8000, never in range
    assign hdr_ch   = in_tdata[DATA_W-1]
                      ? 16'({1'b0, in_tdata[DATA_W-2 -: 15]}) + 16'd1
                      : 16'd0;
    assign hdr_drop = (hdr_ch >= 16'(NUM_CH)) || !TYPE_EN[hdr_ch[CH_W-1:0]];
    assign hdr_runt = in_tlast && (in_tkeep[KEEP_W-1 -: 4] != 4'hF);

    assign out_pending = |out_tvalid;
    assign drain       = out_pending && out_tready[out_ch_q];
    assign in_tready   = (state_q == ST_DROP) || !out_pending || out_tready[out_ch_q];
    assign accept      = in_tvalid && in_tready;
    assign busy        = (state_q != ST_IDLE);

    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        set_ch   = 1'b0;
        load_ch  = cur_ch;
        inc_drop = 1'b0;
        inc_runt = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (hdr_runt) begin
                        inc_runt = 1'b1;
                    end else if (hdr_drop) begin
                        inc_drop = 1'b1;
                        if (!in_tlast) state_d = ST_DROP;
                    end else begin
                        load    = 1'b1;
                        set_ch  = 1'b1;
                        load_ch = hdr_ch[CH_W-1:0];
                        if (!in_tlast) state_d = ST_FWD;
                    end
                end
            end
            ST_FWD: begin
                if (accept) begin
                    load = 1'b1;
                    if (in_tlast) state_d = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (accept && in_tlast) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Single-entry output slot: a new load overrides a same-cycle drain
    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            cur_ch     <= '0;
            out_ch_q   <= '0;
            out_tdata  <= '0;
            out_tkeep  <= '0;
            out_tlast  <= 1'b0;
            out_tvalid <= '0;
        end else begin
            if (set_ch) cur_ch <= load_ch;
            if (load) begin
                out_tdata  <= in_tdata;
                out_tkeep  <= in_tkeep;
                out_tlast  <= in_tlast;
                out_tvalid <= NUM_CH'(1) << load_ch;
                out_ch_q   <= load_ch;
            end else if (drain) begin
                out_tvalid <= '0;
            end
        end
    end

    // Saturating status counters
    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            drop_cnt <= '0;
            runt_cnt <= '0;
        end else begin
            if (inc_drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_W'(1);
            if (inc_runt && (runt_cnt != '1)) runt_cnt <= runt_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_udt_pkt_dispatch.sv
// Directed bench for udt_pkt_dispatch; a second instance with TYPE_EN=8'hFD
// shares the stimulus to exercise the disabled-channel drop path.
module tb_udt_pkt_dispatch;

    logic        core_clk;
    logic        core_rst;
    logic [63:0] in_tdata;
    logic [7:0]  in_tkeep;
    logic        in_tvalid;
    logic        in_tlast;
    logic [7:0]  out_tready;

    logic        in_tready;
    logic [63:0] out_tdata;
    logic [7:0]  out_tkeep;
    logic        out_tlast;
    logic [7:0]  out_tvalid;
    logic [2:0]  cur_ch;
    logic        busy;
    logic [15:0] drop_cnt;
    logic [15:0] runt_cnt;

    logic        b_in_tready;
    logic [63:0] b_out_tdata;
    logic [7:0]  b_out_tkeep;
    logic        b_out_tlast;
    logic [7:0]  b_out_tvalid;
    logic [2:0]  b_cur_ch;
    logic        b_busy;
    logic [15:0] b_drop_cnt;
    logic [15:0] b_runt_cnt;

    int checks   = 0;
    int failures = 0;

    udt_pkt_dispatch #(.DATA_W(64), .NUM_CH(8), .TYPE_EN(8'hFF), .CNT_W(16)) dut (
        .core_clk(core_clk), .core_rst(core_rst),
        .in_tdata(in_tdata), .in_tkeep(in_tkeep), .in_tvalid(in_tvalid),
        .in_tready(in_tready), .in_tlast(in_tlast),
        .out_tdata(out_tdata), .out_tkeep(out_tkeep), .out_tlast(out_tlast),
        .out_tvalid(out_tvalid), .out_tready(out_tready),
        .cur_ch(cur_ch), .busy(busy), .drop_cnt(drop_cnt), .runt_cnt(runt_cnt)
    );

    udt_pkt_dispatch #(.DATA_W(64), .NUM_CH(8), .TYPE_EN(8'hFD), .CNT_W(16)) dut_b (
        .core_clk(core_clk), .core_rst(core_rst),
        .in_tdata(in_tdata), .in_tkeep(in_tkeep), .in_tvalid(in_tvalid),
        .in_tready(b_in_tready), .in_tlast(in_tlast),
        .out_tdata(b_out_tdata), .out_tkeep(b_out_tkeep), .out_tlast(b_out_tlast),
        .out_tvalid(b_out_tvalid), .out_tready(out_tready),
        .cur_ch(b_cur_ch), .busy(b_busy), .drop_cnt(b_drop_cnt), .runt_cnt(b_runt_cnt)
    );

    initial core_clk = 1'b0;
    always #5 core_clk = ~core_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge core_clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] hdr, input logic [31:0] lo,
                         input logic [7:0] keep, input logic last);
        in_tvalid = 1'b1;
        in_tdata  = {hdr, lo};
        in_tkeep  = keep;
        in_tlast  = last;
        #1;
    endtask

    task automatic idle();
        in_tvalid = 1'b0;
        in_tdata  = '0;
        in_tkeep  = '0;
        in_tlast  = 1'b0;
    endtask

    initial begin
        core_rst   = 1'b1;
        out_tready = 8'hFF;
        idle();
        tick();
        tick();
        chk("rst_tvalid", 64'(out_tvalid), 64'h0);
        chk("rst_tdata",  out_tdata,       64'h0);
        chk("rst_tkeep",  64'(out_tkeep),  64'h0);
        chk("rst_tlast",  64'(out_tlast),  64'h0);
        chk("rst_cur_ch", 64'(cur_ch),     64'h0);
        chk("rst_busy",   64'(busy),       64'h0);
        chk("rst_drop",   64'(drop_cnt),   64'h0);
        chk("rst_runt",   64'(runt_cnt),   64'h0);
        core_rst = 1'b0;

        // 3-beat data packet on ch0
        drive(32'h0000_0001, 32'h0000_00A1, 8'hFF, 1'b0);
        chk("t1_rdy0", 64'(in_tready), 64'h1);
        tick();
        chk("t1_v1",    64'(out_tvalid), 64'h01);
        chk("t1_d1",    out_tdata,       64'h0000_0001_0000_00A1);
        chk("t1_busy1", 64'(busy),       64'h1);
        drive(32'h1111_1111, 32'h0000_00A2, 8'hFF, 1'b0);
        chk("t1_rdy1", 64'(in_tready), 64'h1);
        tick();
        chk("t1_v2",  64'(out_tvalid), 64'h01);
        chk("t1_d2",  out_tdata,       64'h1111_1111_0000_00A2);
        chk("t1_l2",  64'(out_tlast),  64'h0);
        drive(32'h2222_2222, 32'h0000_00A3, 8'hF0, 1'b1);
        chk("t1_rdy2", 64'(in_tready), 64'h1);
        tick();
        chk("t1_v3",    64'(out_tvalid), 64'h01);
        chk("t1_l3",    64'(out_tlast),  64'h1);
        chk("t1_k3",    64'(out_tkeep),  64'hF0);
        chk("t1_busy3", 64'(busy),       64'h0);
        idle();
        tick();
        chk("t1_drain", 64'(out_tvalid), 64'h0);

        // ACK (type 2 -> ch3) with a 4-cycle stall on ch3 only
        drive(32'h8002_0000, 32'h0000_00B1, 8'hFF, 1'b0);
        tick();
        chk("t2_v1",  64'(out_tvalid), 64'h08);
        chk("t2_ch",  64'(cur_ch),     64'h3);
        out_tready = 8'hF7;
        drive(32'h3333_3333, 32'h0000_00B2, 8'hFF, 1'b1);
        chk("t2_stall_rdy", 64'(in_tready), 64'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_hold_v", 64'(out_tvalid), 64'h08);
            chk("t2_hold_d", out_tdata,       64'h8002_0000_0000_00B1);
            chk("t2_hold_r", 64'(in_tready),  64'h0);
        end
        out_tready = 8'hFF;
        #1;
        chk("t2_rel_rdy", 64'(in_tready), 64'h1);
        tick();
        chk("t2_v2", 64'(out_tvalid), 64'h08);
        chk("t2_d2", out_tdata,       64'h3333_3333_0000_00B2);
        chk("t2_l2", 64'(out_tlast),  64'h1);
        idle();
        tick();
        chk("t2_drain", 64'(out_tvalid), 64'h0);

        // Type 0x7FFF: unmapped, whole 4-beat packet discarded
        drive(32'hFFFF_0000, 32'h0000_00C1, 8'hFF, 1'b0);
        chk("t3_rdy0", 64'(in_tready), 64'h1);
        tick();
        chk("t3_drop1", 64'(drop_cnt),   64'h1);
        chk("t3_busy1", 64'(busy),       64'h1);
        chk("t3_v1",    64'(out_tvalid), 64'h0);
        drive(32'h5555_5555, 32'h0000_00C2, 8'hFF, 1'b0);
        chk("t3_rdy1", 64'(in_tready), 64'h1);
        tick();
        chk("t3_busy2", 64'(busy), 64'h1);
        drive(32'h6666_6666, 32'h0000_00C3, 8'hFF, 1'b0);
        chk("t3_rdy2", 64'(in_tready), 64'h1);
        tick();
        chk("t3_busy3", 64'(busy), 64'h1);
        drive(32'h7777_7777, 32'h0000_00C4, 8'hFF, 1'b1);
        chk("t3_rdy3", 64'(in_tready), 64'h1);
        tick();
        chk("t3_busy4", 64'(busy),       64'h0);
        chk("t3_drop4", 64'(drop_cnt),   64'h1);
        chk("t3_v4",    64'(out_tvalid), 64'h0);

        // Back-to-back single-beat NAK (type 3 -> ch4) then data on ch0
        drive(32'h8003_0000, 32'h0000_00D1, 8'hFF, 1'b1);
        tick();
        chk("t4_v1", 64'(out_tvalid), 64'h10);
        chk("t4_l1", 64'(out_tlast),  64'h1);
        drive(32'h0000_0000, 32'h0000_00D2, 8'hFF, 1'b1);
        chk("t4_rdy", 64'(in_tready), 64'h1);
        tick();
        chk("t4_v2", 64'(out_tvalid), 64'h01);
        chk("t4_d2", out_tdata,       64'h0000_0000_0000_00D2);
        idle();
        tick();
        chk("t4_drain", 64'(out_tvalid), 64'h0);

        // Runt: single beat with only 3 header bytes present
        drive(32'h0000_0000, 32'h0000_00E1, 8'hE0, 1'b1);
        tick();
        chk("t5_runt",  64'(runt_cnt),   64'h1);
        chk("t5_v",     64'(out_tvalid), 64'h0);
        chk("t5_drop",  64'(drop_cnt),   64'h1);
        idle();
        tick();

        // Handshake (ch1): forwarded with TYPE_EN=FF, dropped with TYPE_EN=FD
        drive(32'h8000_0000, 32'h0000_00F1, 8'hFF, 1'b1);
        tick();
        chk("t5_hs_v",    64'(out_tvalid),   64'h02);
        chk("t5_hs_drop", 64'(drop_cnt),     64'h1);
        chk("t5_b_v",     64'(b_out_tvalid), 64'h0);
        chk("t5_b_drop",  64'(b_drop_cnt),   64'h2);
        chk("t5_b_runt",  64'(b_runt_cnt),   64'h1);
        idle();
        tick();

        // Reset in the middle of a 4-beat packet on ch5
        drive(32'h8004_0000, 32'h0000_0061, 8'hFF, 1'b0);
        tick();
        chk("t6_ch",   64'(cur_ch),     64'h5);
        chk("t6_v",    64'(out_tvalid), 64'h20);
        chk("t6_busy", 64'(busy),       64'h1);
        drive(32'h4444_4444, 32'h0000_0062, 8'hFF, 1'b0);
        core_rst = 1'b1;
        #1;
        chk("t6_rst_v",    64'(out_tvalid), 64'h0);
        chk("t6_rst_d",    out_tdata,       64'h0);
        chk("t6_rst_k",    64'(out_tkeep),  64'h0);
        chk("t6_rst_busy", 64'(busy),       64'h0);
        chk("t6_rst_ch",   64'(cur_ch),     64'h0);
        chk("t6_rst_drop", 64'(drop_cnt),   64'h0);
        chk("t6_rst_runt", 64'(runt_cnt),   64'h0);
        tick();
        core_rst = 1'b0;
        drive(32'h8000_0000, 32'h0000_0071, 8'hFF, 1'b1);
        tick();
        chk("t6_post_v",  64'(out_tvalid), 64'h02);
        chk("t6_post_ch", 64'(cur_ch),     64'h1);
        chk("t6_post_d",  out_tdata,       64'h8000_0000_0000_0071);
        idle();
        tick();
        chk("t6_drain", 64'(out_tvalid), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/udt_pkt_dispatch.md
Name: udt_pkt_dispatch

Overview:
Parametrised UDT packet classifier and router on the post-UDP receive path. It inspects the first beat of each incoming AXI-stream packet for the UDT control flag and type. It then forwards the whole packet, unsplit, to one of NUM_CH handler channels (data, handshake, keep-alive, ACK, NAK, shutdown, ACK2, ...). It replaces the fixed per-type enable decode and shared-ready lock with a registered, backpressure-correct dispatcher that has a drop path and counters.

Parameters:
DATA_W, 64, stream data width in bits; multiple of 32, minimum 32
NUM_CH, 8, number of output channels; channel 0 = data packets, channel k = control type k-1
TYPE_EN, 8'hFF, per-channel enable mask (bit k enables channel k); disabled channels are dropped
CNT_W, 16, width of the saturating status counters

Ports:
core_clk  in  1  block clock
core_rst  in  1  asynchronous active-high reset
in_tdata  in  DATA_W  packet data; first header byte at in_tdata[DATA_W-1 -: 8]
in_tkeep  in  DATA_W/8  byte enables; bit DATA_W/8-1 corresponds to the first byte
in_tvalid  in  1  input beat valid
in_tready  out  1  input beat accepted
in_tlast  in  1  last beat of packet
out_tdata  out  DATA_W  shared output data
out_tkeep  out  DATA_W/8  shared output byte enables
out_tlast  out  1  shared output last
out_tvalid  out  NUM_CH  per-channel valid; at most one bit set
out_tready  in  NUM_CH  per-channel ready
cur_ch  out  clog2(NUM_CH)  channel currently locked
busy  out  1  high while a packet is in progress (FWD or DROP)
drop_cnt  out  CNT_W  packets dropped (unmapped or disabled type)
runt_cnt  out  CNT_W  packets dropped as runts

Behaviour:
- Reset: state IDLE; out_tvalid=0; out_tdata/out_tkeep/out_tlast=0; cur_ch=0; busy=0; both counters=0.
- Header decode on the first beat. H = in_tdata[DATA_W-1 -: 32].
  - H[31]=0: data packet, channel 0.
  - H[31]=1: control packet, channel H[30:16]+1.
  - Compute the channel index in 16 bits, so type 0x7FFF does not wrap into a valid channel.
- Beat classification:
  - Runt: first beat has in_tlast=1 and fewer than 4 keep bytes set (in_tkeep[DATA_W/8-1 -: 4] != 4'hF).
  - Drop: channel index >= NUM_CH, or TYPE_EN[index]=0.
- States:
  - IDLE: on an accepted beat:
    - runt: runt_cnt++, stay IDLE, nothing forwarded.
    - drop, beat not last: drop_cnt++, go DROP.
    - drop, beat last: drop_cnt++, stay IDLE.
    - otherwise: latch cur_ch, load the beat into the output register; go FWD if not last, else stay IDLE.
  - FWD: every accepted beat goes to cur_ch; the accepted beat with in_tlast=1 returns to IDLE.
  - DROP: in_tready=1 every cycle; beats discarded; the accepted tlast beat returns to IDLE.
- Output register (one entry): latency exactly 1 cycle from input acceptance to out_tvalid[cur_ch].
- Ready rule: in_tready = (state==DROP) | !out_pending | out_tready[out_ch].
  - out_ch is the channel of the registered beat.
  - Acceptance and drain in the same cycle must sustain one beat per cycle.
- Backpressure: while a beat is held, out_tdata/out_tkeep/out_tlast/out_tvalid stay stable until out_tready[out_ch]=1.
- Packet boundary: the last beat of packet N may drain in the same cycle the first beat of packet N+1 is accepted, even on a different channel. out_ch updates with the new beat.
- Packet integrity: ready on channels other than out_ch is ignored; no interleaving of packets between channels.
- Counters saturate at all-ones; they never wrap.
- busy = (state != IDLE).
- Reset mid-packet: all state is cleared immediately, including any held output beat. The next accepted beat is decoded as a header. The downstream channel sees a truncated packet with no tlast; this is accepted behaviour.
- in_tkeep is passed through unmodified; no keep compaction is done.

Test Plan:
- Data packet, 3 beats, H=32'h0000_0001, all ready=1 → out_tvalid=8'h01 for 3 consecutive cycles starting 1 cycle after first acceptance; tlast on the 3rd beat; in_tready held 1.
- ACK control, H=32'h8002_0000, 2 beats; out_tready[3] low for 4 cycles mid-packet → out_tvalid=8'h08; output held stable during the stall; in_tready=0 while stalled; other channels' ready ignored.
- Type 0x7FFF (H=32'hFFFF_0000), 4 beats → all beats accepted back-to-back; no out_tvalid; drop_cnt=1; busy high for 3 cycles; next packet routed normally.
- Back-to-back NAK (type 3 → ch4) then data packet, single-beat each with full keep → out_tvalid 8'h10 then 8'h01 on consecutive cycles; no bubble.
- Single beat, tlast=1, tkeep=8'hE0 → runt_cnt=1; nothing forwarded. Then TYPE_EN=8'hFD with a handshake packet (ch1) → drop_cnt=1.
- core_rst asserted during beat 2 of a 4-beat packet → all outputs 0 in the same cycle; the next beat with H=32'h8000_0000 routes to ch1.
